// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared frame definitions for the 001 transmitter and detector
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } seq_state_e;

    // Preamble is sent MSB-first: 0, 0, 1.
    localparam logic [2:0] PREAMBLE = 3'b001;
    localparam int         PRE_LEN  = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_tx_001.sv
// rtl/seq_tx_001.sv - serial frame transmitter: idle-high, preamble 001, MSB-first payload, guard gap
//
// Optional feature macro: SEQ_TX_PARITY_EN (adds one even-parity bit after the payload).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   source offers in_data
//   in_data    payload word (DATA_W bits)
//   in_ready   transmitter can accept a word this cycle
//   tx_out     registered serial line, idle 1
//   busy       frame in progress (preamble, payload, parity or gap)
//   frame_done one-cycle pulse in the last gap cycle
module seq_tx_001
    import seq_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    // One spare bit so the counter never wraps within a frame.
    localparam int CNT_W = $clog2(max3(DATA_W, GAP_CYC, PRE_LEN)) + 1;

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [1:0]        pre_idx;
    logic              accept;
`ifdef SEQ_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign in_ready   = (state_q == IDLE) & ~rst;
    assign accept     = in_valid & in_ready;
    assign tx_out     = tx_q;
    assign busy       = (state_q == PRE) | (state_q == DATA) |
                        (state_q == PAR) | (state_q == GAP);
    assign frame_done = (state_q == GAP) & (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef SEQ_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // tx_d is the line value for the *next* cycle, so every transition
    // also selects the first bit of the state it enters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pre_idx = 2'd0;
`ifdef SEQ_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    shift_d = in_data;
                    tx_d    = PREAMBLE[2];
`ifdef SEQ_TX_PARITY_EN
                    par_d   = ^in_data;
`endif
                end
            end
            PRE: begin
                if (cnt_q == CNT_W'(PRE_LEN - 1)) begin
                    state_d = DATA;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    tx_d    = shift_q[DATA_W-1];
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    pre_idx = 2'd2 - cnt_d[1:0];
                    tx_d    = PREAMBLE[pre_idx];
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
`ifdef SEQ_TX_PARITY_EN
                    state_d = PAR;
                    tx_d    = par_q;
`else
                    state_d = GAP;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
`endif
                end else begin
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    tx_d    = shift_d[DATA_W-1];
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PAR: begin
                state_d = GAP;
                cnt_d   = CNT_W'(GAP_CYC - 1);
            end
`endif
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_tx_001.sv
// tb/tb_seq_tx_001.sv - directed self-checking bench for seq_tx_001
module tb_seq_tx_001;

    localparam int DW = 8;
    localparam int GC = 2;
`ifdef SEQ_TX_PARITY_EN
    localparam int PB = 1;
    localparam logic [31:0] E_A5 = 32'h0D2B;
    localparam logic [31:0] E_FF = 32'h0FFB;
    localparam logic [31:0] E_00 = 32'h0803;
    localparam logic [31:0] E_3C = 32'h09E3;
    localparam logic [31:0] E_W1 = 32'h0F;
`else
    localparam int PB = 0;
    localparam logic [31:0] E_A5 = 32'h0697;
    localparam logic [31:0] E_FF = 32'h07FF;
    localparam logic [31:0] E_00 = 32'h0403;
    localparam logic [31:0] E_3C = 32'h04F3;
    localparam logic [31:0] E_W1 = 32'h07;
`endif
    localparam int FL  = 3 + DW + PB + GC;
    localparam int FL2 = 3 + 1 + PB + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, tx_out, busy, frame_done;
    logic          in_valid2 = 1'b0;
    logic [0:0]    in_data2 = '0;
    logic          in_ready2, tx_out2, busy2, frame_done2;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_tx_001 #(.DATA_W(DW), .GAP_CYC(GC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx_out(tx_out), .busy(busy), .frame_done(frame_done)
    );

    seq_tx_001 #(.DATA_W(1), .GAP_CYC(1)) dut_min (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .tx_out(tx_out2), .busy(busy2), .frame_done(frame_done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Called in cycle N+1; leaves the bench in cycle N+len+1.
    task automatic capture(input int len, output logic [31:0] bits, output logic [31:0] done_m,
                           output logic [31:0] det_m, output logic busy_all);
        logic p1, p2;
        p1 = 1'b1; p2 = 1'b1;
        bits = '0; done_m = '0; det_m = '0; busy_all = 1'b1;
        for (int k = 1; k <= len; k++) begin
            bits     = {bits[30:0], tx_out};
            done_m   = {done_m[30:0], frame_done};
            det_m    = {det_m[30:0], ~p2 & ~p1 & tx_out};
            busy_all = busy_all & busy;
            p2 = p1;
            p1 = tx_out;
            step();
        end
    endtask

    task automatic frame_checks(input string tag, input logic [31:0] exp);
        logic [31:0] bits, done_m, det_m;
        logic        busy_all;
        capture(FL, bits, done_m, det_m, busy_all);
        chk({tag, "_bits"}, bits, exp);
        chk({tag, "_done"}, done_m, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy_all}, 32'd1);
        chk({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] bits, done_m, det_m;
        logic        busy_all;
        int          t1, t2;

        // Reset held: in_valid activity must be ignored.
        in_data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            in_valid = ~in_valid;
            step();
        end
        chk("rst_tx", {31'd0, tx_out}, 32'd1);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("ready_post_rst", {31'd0, in_ready}, 32'd1);

        // Single frame A5; in_data changes after accept.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_valid = 1'b0;
        in_data  = 8'h5A;
        frame_checks("a5", E_A5);

        // Back-to-back FF then 00 with in_valid held.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        chk("b2b_ready1", {31'd0, in_ready}, 32'd1);
        step();
        t1 = cyc;
        in_data = 8'h00;
        capture(FL, bits, done_m, det_m, busy_all);
        chk("ff_bits", bits, E_FF);
        chk("ff_det", det_m, 32'd1 << (FL - 3));
        chk("ff_done", done_m, 32'd1);
        chk("b2b_ready2", {31'd0, in_ready}, 32'd1);
        step();
        t2 = cyc;
        in_valid = 1'b0;
        chk("b2b_spacing", t2 - t1, FL + 1);
        frame_checks("zero", E_00);

        // Reset mid-payload at N+6.
        in_valid = 1'b1;
        in_data  = 8'h00;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("mid_tx_before", {31'd0, tx_out}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("mid_tx_async", {31'd0, tx_out}, 32'd1);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_ready", {31'd0, in_ready}, 32'd0);
        step();
        #1 rst = 1'b0;
        #1;
        chk("mid_ready_release", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        step();
        in_valid = 1'b0;
        frame_checks("x3c", E_3C);

`ifdef SEQ_TX_PARITY_EN
        in_valid = 1'b1;
        in_data  = 8'h07;
        step();
        in_valid = 1'b0;
        frame_checks("par07", 32'h083F);
        in_valid = 1'b1;
        in_data  = 8'h03;
        step();
        in_valid = 1'b0;
        frame_checks("par03", 32'h081B);
`endif

        // DATA_W=1, GAP_CYC=1 boundary instance.
        in_valid2 = 1'b1;
        in_data2  = 1'b1;
        chk("w1_ready", {31'd0, in_ready2}, 32'd1);
        step();
        in_valid2 = 1'b0;
        bits = '0; done_m = '0; busy_all = 1'b1;
        for (int k = 1; k <= FL2; k++) begin
            bits     = {bits[30:0], tx_out2};
            done_m   = {done_m[30:0], frame_done2};
            busy_all = busy_all & busy2;
            step();
        end
        chk("w1_bits", bits, E_W1);
        chk("w1_done", done_m, 32'd1);
        chk("w1_busy", {31'd0, busy_all}, 32'd1);
        chk("w1_ready_after", {31'd0, in_ready2}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
